rof_run_controller: RTL and testbench
=====================================

Name: rof_run_controller

Overview:
- Sequencer for the rank-order filter datapath.
- Issues sample ROM addresses and a filter clock-enable in place of a gated clock.
- Delays write strobes to match ROM and filter latency, so each filter result lands in result RAM at its sample index.
- After the run, steps a readback address from debounced up/down pulses for the seven-segment display.

Parameters:
- NUM_SAMPLES, 255, samples per run; addresses 0..NUM_SAMPLES-1.
- ADDR_BITS, 8, width of ROM/RAM addresses; must satisfy 2**ADDR_BITS >= NUM_SAMPLES.
- ROM_LAT, 1, cycles from rom_addr to valid sample at filter input.
- FILTER_LAT, 1, cycles from sample at filter input to valid filter output.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse; begins a run.
- rd_up, input, 1, single-cycle debounced pulse; increment readback address.
- rd_down, input, 1, single-cycle debounced pulse; decrement readback address.
- rom_addr, output, ADDR_BITS, sample ROM read address.
- rof_en, output, 1, clock-enable for rank-order filter window shift.
- ram_we, output, 1, result RAM write enable.
- ram_waddr, output, ADDR_BITS, result RAM write address.
- rd_addr, output, ADDR_BITS, result RAM read address for display.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, high in DONE.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; latency pipelines cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start -> RUN with rom_addr=0; otherwise remain.
- RUN:
  - Each cycle: rom_addr increments by 1; issue flag pushed into a delay line of depth ROM_LAT.
  - When rom_addr == NUM_SAMPLES-1 is issued, next state is DRAIN; rom_addr holds at NUM_SAMPLES-1.
- rof_en: equals the issue flag delayed ROM_LAT cycles, so the filter shifts exactly NUM_SAMPLES times per run.
- ram_we: equals rof_en delayed FILTER_LAT cycles.
- ram_waddr:
  - Counter, 0 at run start; increments after each cycle with ram_we=1.
  - First write goes to address 0; last write goes to NUM_SAMPLES-1.
- DRAIN:
  - No new issues.
  - Transition to DONE in the cycle after the final ram_we (write to NUM_SAMPLES-1).
  - Total RUN+DRAIN duration: NUM_SAMPLES+ROM_LAT+FILTER_LAT cycles.
- DONE: done=1, busy=0; start -> RUN (restart, rom_addr and ram_waddr reset to 0); rd_addr is retained.
- rd_addr stepping:
  - Active in IDLE and DONE only; pulses ignored while busy.
  - rd_up alone: +1, wrapping NUM_SAMPLES-1 -> 0.
  - rd_down alone: -1, wrapping 0 -> NUM_SAMPLES-1.
  - rd_up and rd_down in the same cycle: no change.
- start while busy: ignored.
- Reset mid-run: immediate return to IDLE; ram_we drops asynchronously; a partial run is not resumed.
- Width rules:
  - All address arithmetic is ADDR_BITS wide.
  - Wrap is at NUM_SAMPLES, not at 2**ADDR_BITS.

Optional Feature:
- Macro: ROF_RDADDR_SATURATE_EN.
- Defined: rd_addr saturates; rd_up at NUM_SAMPLES-1 holds, rd_down at 0 holds.
- Undefined: wrap-around as in Behaviour.

Test Plan:
- Reset then start, NUM_SAMPLES=255, ROM_LAT=1, FILTER_LAT=1:
  - rom_addr counts 0..254.
  - rof_en high for exactly 255 cycles, starting 1 cycle after the first issue.
  - ram_we high for 255 cycles with ram_waddr 0..254.
  - done rises 257 cycles after start.
- In DONE with rd_addr=0:
  - 3 rd_up pulses -> rd_addr=3.
  - 1 rd_down from 0 -> rd_addr=254 (macro off) or rd_addr=0 (macro on).
- rd_up and rd_down in the same cycle with rd_addr=10 -> rd_addr stays 10; rd_up pulse during busy -> rd_addr unchanged.
- Assert rst low at rom_addr=100 during RUN:
  - Same cycle: all outputs 0, state IDLE.
  - After release, a new start runs a full 255-sample sequence from address 0.
- start pulse while busy at rom_addr=50 -> no restart; sequence continues to 254 unchanged.
- Second start in DONE:
  - ram_waddr restarts at 0; rd_addr keeps its prior value.
  - done deasserts the cycle after start.

Source files
------------

// File: rtl/rof_run_controller_if.sv
// Handshake/bus bundle for the rank-order filter run controller.
//   master : the controlling side (user buttons/start, or a bench) drives
//            start / rd_up / rd_down and observes the sequencer outputs.
//   slave  : rof_run_controller, which receives the pulses and drives
//            rom_addr, rof_en, ram_we, ram_waddr, rd_addr, busy and done.
interface rof_run_controller_if #(
  parameter int ADDR_BITS = 8
) ();
  logic                 start;
  logic                 rd_up;
  logic                 rd_down;
  logic [ADDR_BITS-1:0] rom_addr;
  logic                 rof_en;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_waddr;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 busy;
  logic                 done;

  modport master (
    output start, rd_up, rd_down,
    input  rom_addr, rof_en, ram_we, ram_waddr, rd_addr, busy, done
  );

  modport slave (
    input  start, rd_up, rd_down,
    output rom_addr, rof_en, ram_we, ram_waddr, rd_addr, busy, done
  );
endinterface

// File: rtl/rof_run_controller.sv
// Run sequencer for the rank-order filter datapath.
// Issues sample ROM addresses 0..NUM_SAMPLES-1, produces the filter
// clock-enable (issue delayed by ROM_LAT) and the result RAM write strobe
// (rof_en delayed by FILTER_LAT) so that each result is written at its own
// sample index. Once the run is complete, rd_addr is stepped by debounced
// up/down pulses for the seven-segment readback.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - rof_run_controller_if.slave (start, rd_up, rd_down in;
//          rom_addr, rof_en, ram_we, ram_waddr, rd_addr, busy, done out)
//
// Build option: define ROF_RDADDR_SATURATE_EN to make rd_addr saturate at
// 0 and NUM_SAMPLES-1 instead of wrapping.
module rof_run_controller #(
  parameter int NUM_SAMPLES = 255,
  parameter int ADDR_BITS   = 8,
  parameter int ROM_LAT     = 1,
  parameter int FILTER_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  rof_run_controller_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(NUM_SAMPLES - 1);
  localparam logic [ADDR_BITS-1:0] ONE  = ADDR_BITS'(1);

  state_t                state;
  logic                  issue;
  logic [ROM_LAT-1:0]    rom_pipe;
  logic [FILTER_LAT-1:0] flt_pipe;

  // One sample is issued to the ROM in every RUN cycle, including the one
  // holding the final address.
  assign issue = (state == RUN);

  // Latency delay lines; the newest flag enters at bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_pipe <= '0;
      flt_pipe <= '0;
    end else begin
      rom_pipe <= ROM_LAT'({rom_pipe, issue});
      flt_pipe <= FILTER_LAT'({flt_pipe, rom_pipe[ROM_LAT-1]});
    end
  end

  assign bus.rof_en = rom_pipe[ROM_LAT-1];
  assign bus.ram_we = flt_pipe[FILTER_LAT-1];

  // Main FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bus.rom_addr  <= '0;
      bus.ram_waddr <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      // Write address follows the delayed strobe; a start below overrides.
      if (bus.ram_we)
        bus.ram_waddr <= (bus.ram_waddr == LAST) ? '0 : bus.ram_waddr + ONE;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state         <= RUN;
            bus.rom_addr  <= '0;
            bus.ram_waddr <= '0;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
          end
        end
        RUN: begin
          if (bus.rom_addr == LAST) state <= DRAIN;
          else                      bus.rom_addr <= bus.rom_addr + ONE;
        end
        DRAIN: begin
          // Leave once the write to the final index has happened.
          if (bus.ram_we && bus.ram_waddr == LAST) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Readback address; simultaneous up and down cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rd_addr <= '0;
    end else if ((state == IDLE || state == DONE) && (bus.rd_up ^ bus.rd_down)) begin
`ifdef ROF_RDADDR_SATURATE_EN
      if (bus.rd_up) begin
        if (bus.rd_addr != LAST) bus.rd_addr <= bus.rd_addr + ONE;
      end else begin
        if (bus.rd_addr != '0)   bus.rd_addr <= bus.rd_addr - ONE;
      end
`else
      if (bus.rd_up)
        bus.rd_addr <= (bus.rd_addr == LAST) ? '0 : bus.rd_addr + ONE;
      else
        bus.rd_addr <= (bus.rd_addr == '0) ? LAST : bus.rd_addr - ONE;
`endif
    end
  end

endmodule

// File: tb/tb_rof_run_controller.sv
// Directed bench for rof_run_controller (NUM_SAMPLES=255, ROM_LAT=1,
// FILTER_LAT=1). Expected RAM write addresses are queued when a run is
// started and popped whenever the DUT strobes ram_we.
module tb_rof_run_controller;
  localparam int N = 255;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] exp_wq[$];
  logic [7:0] exp_rd;

  rof_run_controller_if #(.ADDR_BITS(8)) bus ();

  rof_run_controller #(
    .NUM_SAMPLES(N), .ADDR_BITS(8), .ROM_LAT(1), .FILTER_LAT(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the next queued index.
  always @(negedge clk) begin
    if (rst && bus.ram_we) begin
      if (exp_wq.size() == 0) begin
        check("unexpected_ram_we", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_wq.pop_front();
        check("ram_waddr", 32'(bus.ram_waddr), 32'(e));
      end
    end
  end

  function automatic logic [7:0] rd_model(input logic [7:0] cur, input bit up, input bit dn);
    if (up && !dn) begin
`ifdef ROF_RDADDR_SATURATE_EN
      return (cur == 8'(N-1)) ? cur : 8'(cur + 8'd1);
`else
      return (cur == 8'(N-1)) ? 8'd0 : 8'(cur + 8'd1);
`endif
    end
    if (dn && !up) begin
`ifdef ROF_RDADDR_SATURATE_EN
      return (cur == 8'd0) ? cur : 8'(cur - 8'd1);
`else
      return (cur == 8'd0) ? 8'(N-1) : 8'(cur - 8'd1);
`endif
    end
    return cur;
  endfunction

  task automatic pulse(input string tag, input bit up, input bit dn);
    bus.rd_up = up; bus.rd_down = dn;
    @(posedge clk); #1;
    bus.rd_up = 1'b0; bus.rd_down = 1'b0;
    exp_rd = rd_model(exp_rd, up, dn);
    check(tag, 32'(bus.rd_addr), 32'(exp_rd));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"},  32'(bus.rom_addr),  0);
    check({tag, "_rof_en"},    32'(bus.rof_en),    0);
    check({tag, "_ram_we"},    32'(bus.ram_we),    0);
    check({tag, "_ram_waddr"}, 32'(bus.ram_waddr), 0);
    check({tag, "_rd_addr"},   32'(bus.rd_addr),   0);
    check({tag, "_busy"},      32'(bus.busy),      0);
    check({tag, "_done"},      32'(bus.done),      0);
  endtask

  // One run from IDLE/DONE. Optional injections (-1 = off): a start pulse
  // and an rd_up pulse at a given cycle while busy, or reset at a cycle.
  task automatic run_seq(input string tag, input int start_at, input int up_at, input int rst_at);
    int n_rof, n_we, first_rof, k;
    bit got_done;
    exp_wq.delete();
    for (int i = 0; i < N; i++) exp_wq.push_back(8'(i));
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy0"},  32'(bus.busy),      1);
    check({tag, "_done0"},  32'(bus.done),      0);
    check({tag, "_waddr0"}, 32'(bus.ram_waddr), 0);
    n_rof = 0; n_we = 0; first_rof = -1; got_done = 1'b0;
    for (k = 0; k < 400; k++) begin
      if (bus.done) begin got_done = 1'b1; break; end
      check({tag, "_rom_addr"}, 32'(bus.rom_addr), (k < N) ? k : N-1);
      if (k == rst_at) begin
        rst = 1'b0;
        #1;
        check_all_zero({tag, "_midrst"});
        exp_wq.delete();
        exp_rd = 8'd0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (bus.rof_en) begin
        n_rof++;
        if (first_rof < 0) first_rof = k;
      end
      if (bus.ram_we) n_we++;
      bus.start = (k == start_at);
      bus.rd_up = (k == up_at);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.rd_up = 1'b0;
    end
    check({tag, "_done_seen"}, 32'(got_done), 1);
    check({tag, "_done_lat"},  k, N + 2);
    check({tag, "_rof_cnt"},   n_rof, N);
    check({tag, "_rof_first"}, first_rof, 1);
    check({tag, "_we_cnt"},    n_we, N);
    check({tag, "_sb_empty"},  exp_wq.size(), 0);
    check({tag, "_busy_end"},  32'(bus.busy), 0);
    check({tag, "_rd_keep"},   32'(bus.rd_addr), 32'(exp_rd));
  endtask

  initial begin
    checks = 0; errors = 0; exp_rd = 8'd0;
    rst = 1'b0;
    bus.start = 1'b0; bus.rd_up = 1'b0; bus.rd_down = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    run_seq("run1", -1, -1, -1);

    // Readback stepping in DONE.
    for (int i = 0; i < 3; i++) pulse("rd_up", 1'b1, 1'b0);
    check("rd_after_3up", 32'(bus.rd_addr), 3);
    for (int i = 0; i < 3; i++) pulse("rd_down", 1'b0, 1'b1);
    pulse("rd_down_at0", 1'b0, 1'b1);
`ifdef ROF_RDADDR_SATURATE_EN
    check("rd_low_edge", 32'(bus.rd_addr), 0);
`else
    check("rd_low_edge", 32'(bus.rd_addr), N-1);
`endif
    pulse("rd_up_edge", 1'b1, 1'b0);
    for (int i = 0; i < 300 && exp_rd != 8'd10; i++) pulse("rd_seek", 1'b1, 1'b0);
    pulse("rd_both", 1'b1, 1'b1);
    check("rd_both_10", 32'(bus.rd_addr), 10);

    // Restart from DONE with start and rd_up injected while busy.
    run_seq("run2", 50, 60, -1);

    // Reset at rom_addr=100, then a clean full run.
    run_seq("abort", -1, -1, 100);
    @(posedge clk); #1;
    check_all_zero("post_rst");
    run_seq("run3", -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
